// File: rtl/dma_cycle_stealer_if.sv
// Bus-side signal bundle of the cycle-stealing DMA engine.
// The slave modport is the DMA engine; the master modport is the system around it.
interface dma_cycle_stealer_if;
  logic        trig;
  logic [7:0]  trig_page;
  logic        cpu_rw;
  logic [7:0]  mem_data_in;
  logic        rdy;
  logic        bus_grant;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_data_out;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output trig, trig_page, cpu_rw, mem_data_in,
    input  rdy, bus_grant, dma_addr, dma_rw, dma_data_out, busy, done, overrun
  );

  modport slave (
    input  trig, trig_page, cpu_rw, mem_data_in,
    output rdy, bus_grant, dma_addr, dma_rw, dma_data_out, busy, done, overrun
  );
endinterface

// File: rtl/dma_cycle_stealer.sv
// Block-copy DMA that halts a 6502 through its rdy line and copies LEN bytes
// from {page,idx} to a fixed destination register, one read/write pair per byte.
module dma_cycle_stealer #(
  parameter int          LEN       = 256,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter bit          ALIGN_EN  = 1'b1
) (
  input  logic               clk_1,
  input  logic               res_n,
  dma_cycle_stealer_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t      state_reg, state_next;
  logic [7:0]  page_reg, page_next;
  logic [7:0]  idx_reg, idx_next;
  logic        phase_reg;

  logic        rdy_reg;
  logic        grant_reg;
  logic [15:0] addr_reg, addr_next;
  logic        rw_reg, rw_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        busy_reg;
  logic        done_reg, done_next;
  logic        overrun_reg, overrun_next;

  always_comb begin
    state_next   = state_reg;
    page_next    = page_reg;
    idx_next     = idx_reg;
    done_next    = 1'b0;
    overrun_next = io.trig && (state_reg != S_IDLE);
    unique case (state_reg)
      S_IDLE: begin
        if (io.trig) begin
          page_next  = io.trig_page;
          idx_next   = 8'd0;
          state_next = S_WAIT;
        end
      end
      // The CPU only freezes on a read cycle, so keep off the bus until it reads.
      S_WAIT: begin
        if (io.cpu_rw) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        state_next = (ALIGN_EN && phase_reg) ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        state_next = S_READ;
      end
      S_READ: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (idx_reg == LAST_IDX) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = S_READ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the state being entered so that they are
  // registered yet line up with the state they belong to.
  always_comb begin
    addr_next  = 16'h0000;
    rw_next    = 1'b1;
    wdata_next = 8'h00;
    unique case (state_next)
      S_ALIGN, S_READ: begin
        addr_next = {page_next, idx_next};
      end
      S_WRITE: begin
        // WRITE is only ever entered from READ; this register is the data latch.
        addr_next  = DEST_ADDR;
        rw_next    = 1'b0;
        wdata_next = io.mem_data_in;
      end
      default: begin
        addr_next = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (!res_n) begin
      state_reg   <= S_IDLE;
      page_reg    <= 8'h00;
      idx_reg     <= 8'h00;
      phase_reg   <= 1'b0;
      rdy_reg     <= 1'b1;
      grant_reg   <= 1'b0;
      addr_reg    <= 16'h0000;
      rw_reg      <= 1'b1;
      wdata_reg   <= 8'h00;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      page_reg    <= page_next;
      idx_reg     <= idx_next;
      phase_reg   <= ~phase_reg;
      rdy_reg     <= (state_next == S_IDLE);
      grant_reg   <= (state_next == S_ALIGN) || (state_next == S_READ) ||
                     (state_next == S_WRITE);
      addr_reg    <= addr_next;
      rw_reg      <= rw_next;
      wdata_reg   <= wdata_next;
      busy_reg    <= (state_next != S_IDLE);
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign io.rdy          = rdy_reg;
  assign io.bus_grant    = grant_reg;
  assign io.dma_addr     = addr_reg;
  assign io.dma_rw       = rw_reg;
  assign io.dma_data_out = wdata_reg;
  assign io.busy         = busy_reg;
  assign io.done         = done_reg;
  assign io.overrun      = overrun_reg;

endmodule

// File: tb/tb_dma_cycle_stealer.sv
// Scoreboard bench: instance 0 copies 4 bytes, instance 1 copies 256 bytes.
module tb_dma_cycle_stealer;

  localparam logic [15:0] DEST = 16'h2004;
  localparam logic [1:0]  EV_READ  = 2'd0;
  localparam logic [1:0]  EV_WRITE = 2'd1;
  localparam logic [1:0]  EV_DONE  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n = 1'b0;
  logic [1:0]  trig_v = 2'b00;
  logic [1:0]  cpu_rw_v = 2'b11;
  logic [7:0]  page_a [2];
  logic [1:0]  rdy_v, grant_v, rw_v, busy_v, done_v, ovr_v;
  logic [15:0] addr_a [2];
  logic [7:0]  wdata_a [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int run_cnt [2];
  int exp_ovr [2];
  ev_t exp_q [2][$];
  int exp_stall [2][$];

  // Memory contents seen by the DMA: an arbitrary but address-dependent byte.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dma_cycle_stealer_if bus();
    assign bus.trig        = trig_v[gi];
    assign bus.trig_page   = page_a[gi];
    assign bus.cpu_rw      = cpu_rw_v[gi];
    assign bus.mem_data_in = mem_f(bus.dma_addr);
    assign rdy_v[gi]   = bus.rdy;
    assign grant_v[gi] = bus.bus_grant;
    assign rw_v[gi]    = bus.dma_rw;
    assign busy_v[gi]  = bus.busy;
    assign done_v[gi]  = bus.done;
    assign ovr_v[gi]   = bus.overrun;
    assign addr_a[gi]  = bus.dma_addr;
    assign wdata_a[gi] = bus.dma_data_out;

    dma_cycle_stealer #(
      .LEN      ((gi == 0) ? 4 : 256),
      .DEST_ADDR(DEST),
      .ALIGN_EN (1'b1)
    ) u_dut (
      .clk_1(clk),
      .res_n(res_n),
      .io   (bus.slave)
    );

    always @(negedge clk) begin : mon
      ev_t act;
      ev_t exp;
      int  es;
      if (rdy_v[gi] === 1'b0) begin
        run_cnt[gi] = run_cnt[gi] + 1;
      end else if (run_cnt[gi] > 0) begin
        checks++;
        if (exp_stall[gi].size() == 0) begin
          failures++;
          $display("FAIL stall%0d got %0d low cycles, required none", gi, run_cnt[gi]);
        end else begin
          es = exp_stall[gi].pop_front();
          if (run_cnt[gi] != es) begin
            failures++;
            $display("FAIL stall%0d got %0d low cycles, required %0d", gi, run_cnt[gi], es);
          end
        end
        run_cnt[gi] = 0;
      end
      if (ovr_v[gi] === 1'b1) begin
        checks++;
        if (exp_ovr[gi] == 0) begin
          failures++;
          $display("FAIL overrun%0d got pulse, required none", gi);
        end else begin
          exp_ovr[gi] = exp_ovr[gi] - 1;
        end
      end
      if (grant_v[gi] === 1'b1 || done_v[gi] === 1'b1) begin
        if (done_v[gi] === 1'b1) begin
          act = '{kind: EV_DONE, addr: 16'h0000, data: 8'h00};
        end else if (rw_v[gi] === 1'b1) begin
          act = '{kind: EV_READ, addr: addr_a[gi], data: 8'h00};
        end else begin
          act = '{kind: EV_WRITE, addr: addr_a[gi], data: wdata_a[gi]};
        end
        checks++;
        if (exp_q[gi].size() == 0) begin
          failures++;
          $display("FAIL ev%0d got kind=%0d addr=%h data=%h, required nothing",
                   gi, act.kind, act.addr, act.data);
        end else begin
          exp = exp_q[gi].pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL ev%0d got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                     gi, act.kind, act.addr, act.data, exp.kind, exp.addr, exp.data);
          end
        end
      end
    end
  end

  always @(posedge clk) cyc <= res_n ? cyc + 1 : 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input int inst, input logic [7:0] page, input int len,
                           input int w, input int a);
    logic [15:0] src;
    if (a != 0) exp_q[inst].push_back('{kind: EV_READ, addr: {page, 8'h00}, data: 8'h00});
    for (int i = 0; i < len; i++) begin
      src = {page, 8'(i)};
      exp_q[inst].push_back('{kind: EV_READ, addr: src, data: 8'h00});
      exp_q[inst].push_back('{kind: EV_WRITE, addr: DEST, data: mem_f(src)});
    end
    exp_q[inst].push_back('{kind: EV_DONE, addr: 16'h0000, data: 8'h00});
    exp_stall[inst].push_back(w + 1 + a + 2 * len);
  endtask

  // Issue a trigger now and hold cpu_rw low for the first w-1 WAIT cycles.
  task automatic trig_xfer(input int inst, input logic [7:0] page, input int w, output int a);
    int len;
    len = (inst == 0) ? 4 : 256;
    a = (((cyc + w + 1) % 2) == 1) ? 1 : 0;
    push_xfer(inst, page, len, w, a);
    trig_v[inst] = 1'b1;
    page_a[inst] = page;
    step();
    trig_v[inst] = 1'b0;
    for (int i = 0; i < w; i++) begin
      cpu_rw_v[inst] = (i == w - 1);
      chk("wait_grant", grant_v[inst], 0);
      chk("wait_busy", busy_v[inst], 1);
      if (i < w - 1) step();
    end
  endtask

  task automatic wait_parity(input int want);
    for (int i = 0; i < 3 && (cyc % 2) != want; i++) step();
  endtask

  task automatic wait_idle(input int inst, input int budget);
    int n;
    n = 0;
    while ((exp_q[inst].size() != 0 || exp_stall[inst].size() != 0 || busy_v[inst] !== 1'b0)
           && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle%0d got %0d events outstanding after %0d cycles, required 0",
               inst, exp_q[inst].size(), budget);
      exp_q[inst].delete();
      exp_stall[inst].delete();
    end
  endtask

  task automatic poll_read(input int inst, input logic [15:0] addr, input int budget);
    int n;
    n = 0;
    while (!(grant_v[inst] === 1'b1 && rw_v[inst] === 1'b1 && addr_a[inst] === addr)
           && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL poll%0d read of %h not seen within %0d cycles", inst, addr, budget);
    end
  endtask

  initial begin
    int a;
    page_a[0] = 8'h00;
    page_a[1] = 8'h00;
    run_cnt[0] = 0;
    run_cnt[1] = 0;
    exp_ovr[0] = 0;
    exp_ovr[1] = 0;

    res_n = 1'b0;
    step();
    step();
    chk("rst_rdy", rdy_v[0], 1);
    chk("rst_grant", grant_v[0], 0);
    chk("rst_addr", addr_a[0], 16'h0000);
    chk("rst_rw", rw_v[0], 1);
    chk("rst_wdata", wdata_a[0], 8'h00);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_ovr", ovr_v[0], 0);
    chk("rst_addr_big", addr_a[1], 16'h0000);
    res_n = 1'b1;
    step();

    // 1: plain transfer, no alignment cycle
    wait_parity(0);
    trig_xfer(0, 8'h02, 1, a);
    wait_idle(0, 40);

    // 2: CPU still writing for three cycles after the trigger
    wait_parity(1);
    trig_xfer(0, 8'h02, 4, a);
    wait_idle(0, 40);

    // 3: HALT on an odd cycle inserts an ALIGN dummy read
    wait_parity(1);
    trig_xfer(0, 8'h05, 1, a);
    chk("align_a", a, 1);
    wait_idle(0, 40);

    // 4: second trigger while reading byte 1
    wait_parity(0);
    trig_xfer(0, 8'h06, 1, a);
    poll_read(0, 16'h0601, 20);
    trig_v[0] = 1'b1;
    page_a[0] = 8'h77;
    exp_ovr[0] = exp_ovr[0] + 1;
    step();
    trig_v[0] = 1'b0;
    wait_idle(0, 40);
    chk("ovr_left", exp_ovr[0], 0);

    // 5: reset during the second WRITE abandons the transfer
    wait_parity(0);
    trig_xfer(0, 8'h09, 1, a);
    poll_read(0, 16'h0901, 20);
    step();
    chk("abort_in_write", rw_v[0], 0);
    exp_q[0].delete();
    exp_stall[0].delete();
    exp_stall[0].push_back(6 + a);
    res_n = 1'b0;
    step();
    res_n = 1'b1;
    chk("abort_rdy", rdy_v[0], 1);
    chk("abort_grant", grant_v[0], 0);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_done", done_v[0], 0);
    for (int i = 0; i < 3; i++) step();
    chk("abort_stall_left", exp_stall[0].size(), 0);
    trig_xfer(0, 8'h0A, 1, a);
    wait_idle(0, 40);

    // 7: trigger in the very cycle done is high is accepted
    trig_xfer(0, 8'h0B, 1, a);
    for (int i = 0; i < 20 && done_v[0] !== 1'b1; i++) step();
    chk("done_seen", done_v[0], 1);
    trig_xfer(0, 8'h0C, 1, a);
    wait_idle(0, 40);

    // 6: full 256-byte copy from the top page
    wait_parity(0);
    trig_xfer(1, 8'hFF, 1, a);
    wait_idle(1, 700);

    step();
    chk("q0_left", exp_q[0].size(), 0);
    chk("q1_left", exp_q[1].size(), 0);
    chk("ovr1_left", exp_ovr[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
